// File: rtl/cbm2_kbd_pkg.sv
// CBM-II keyboard shared types and keymap.
// PS/2 set-2 scancodes mapped onto the 16x6 CBM-II key matrix.
package cbm2_kbd_pkg;

    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [3:0] SHIFT_COL = 4'd0;
    localparam logic [2:0] SHIFT_ROW = 3'd4;

    typedef struct packed {
        logic       hit;
        logic [3:0] col;
        logic [2:0] row;
        logic [1:0] shift_id;
    } kbd_entry_t;

    function automatic kbd_entry_t kbd_key(input int c, input int r);
        kbd_entry_t e;
        e.hit      = 1'b1;
        e.col      = 4'(c);
        e.row      = 3'(r);
        e.shift_id = 2'd0;
        return e;
    endfunction

    function automatic kbd_entry_t kbd_lookup(input logic ext,
                                              input logic [7:0] code);
        kbd_entry_t e;
        e = '0;
        if (!ext) begin
            case (code)
                8'h05: e = kbd_key(0, 0);
                8'h06: e = kbd_key(1, 0);
                8'h04: e = kbd_key(2, 0);
                8'h0C: e = kbd_key(3, 0);
                8'h03: e = kbd_key(4, 0);
                8'h0B: e = kbd_key(5, 0);
                8'h83: e = kbd_key(6, 0);
                8'h0A: e = kbd_key(7, 0);
                8'h01: e = kbd_key(8, 0);
                8'h09: e = kbd_key(9, 0);
                8'h76: e = kbd_key(0, 1);
                8'h16: e = kbd_key(1, 1);
                8'h1E: e = kbd_key(2, 1);
                8'h26: e = kbd_key(3, 1);
                8'h25: e = kbd_key(4, 1);
                8'h2E: e = kbd_key(5, 1);
                8'h36: e = kbd_key(6, 1);
                8'h3D: e = kbd_key(7, 1);
                8'h3E: e = kbd_key(8, 1);
                8'h46: e = kbd_key(9, 1);
                8'h45: e = kbd_key(10, 1);
                8'h4E: e = kbd_key(11, 1);
                8'h55: e = kbd_key(12, 1);
                8'h66: e = kbd_key(13, 1);
                8'h0D: e = kbd_key(0, 2);
                8'h15: e = kbd_key(1, 2);
                8'h1D: e = kbd_key(2, 2);
                8'h24: e = kbd_key(3, 2);
                8'h2D: e = kbd_key(4, 2);
                8'h2C: e = kbd_key(5, 2);
                8'h35: e = kbd_key(6, 2);
                8'h3C: e = kbd_key(7, 2);
                8'h43: e = kbd_key(8, 2);
                8'h44: e = kbd_key(9, 2);
                8'h4D: e = kbd_key(10, 2);
                8'h54: e = kbd_key(11, 2);
                8'h5B: e = kbd_key(12, 2);
                8'h5A: e = kbd_key(13, 2);
                8'h58: e = kbd_key(0, 3);
                8'h1C: e = kbd_key(1, 3);
                8'h1B: e = kbd_key(2, 3);
                8'h23: e = kbd_key(3, 3);
                8'h2B: e = kbd_key(4, 3);
                8'h34: e = kbd_key(5, 3);
                8'h33: e = kbd_key(6, 3);
                8'h3B: e = kbd_key(7, 3);
                8'h42: e = kbd_key(8, 3);
                8'h4B: e = kbd_key(9, 3);
                8'h4C: e = kbd_key(10, 3);
                8'h52: e = kbd_key(11, 3);
                8'h5D: e = kbd_key(12, 3);
                SC_LSHIFT: begin
                    e = kbd_key(int'(SHIFT_COL), int'(SHIFT_ROW));
                    e.shift_id = 2'd1;
                end
                SC_RSHIFT: begin
                    e = kbd_key(int'(SHIFT_COL), int'(SHIFT_ROW));
                    e.shift_id = 2'd2;
                end
                8'h1A: e = kbd_key(1, 4);
                8'h22: e = kbd_key(2, 4);
                8'h21: e = kbd_key(3, 4);
                8'h2A: e = kbd_key(4, 4);
                8'h32: e = kbd_key(5, 4);
                8'h31: e = kbd_key(6, 4);
                8'h3A: e = kbd_key(7, 4);
                8'h41: e = kbd_key(8, 4);
                8'h49: e = kbd_key(9, 4);
                8'h4A: e = kbd_key(10, 4);
                8'h14: e = kbd_key(0, 5);
                8'h29: e = kbd_key(1, 5);
                8'h70: e = kbd_key(10, 5);
                8'h69: e = kbd_key(11, 5);
                8'h75: e = kbd_key(12, 5);
                8'h7D: e = kbd_key(13, 5);
                default: e = '0;
            endcase
        end else begin
            case (code)
                8'h72: e = kbd_key(10, 0);
                8'h75: e = kbd_key(11, 0);
                8'h6B: e = kbd_key(12, 0);
                8'h74: e = kbd_key(13, 0);
                8'h6C: e = kbd_key(14, 0);
                8'h71: e = kbd_key(14, 1);
                8'h5A: e = kbd_key(14, 2);
                8'h4A: e = kbd_key(15, 0);
                default: e = '0;
            endcase
        end
        return e;
    endfunction

endpackage

// File: rtl/cbm2_keymap.sv
// Registered scancode lookup (pipeline stage 1).
// 512-entry ROM addressed by {ext, code}.
module cbm2_keymap
    import cbm2_kbd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       ext,
    input  logic [7:0] code,
    input  logic       pressed,
    output logic       valid,
    output kbd_entry_t entry,
    output logic       key_down
);

    // ROM read and event data, no reset needed on the data path
    always_ff @(posedge clk) begin
        entry    <= kbd_lookup(ext, code);
        key_down <= pressed;
    end

    // Stage valid, cleared by reset so in-flight events are dropped
    always_ff @(posedge clk) begin
        if (reset) valid <= 1'b0;
        else       valid <= req;
    end

endmodule

// File: rtl/cbm2_keyboard.sv
// CBM-II keyboard matrix responder for TPI2.
// PS/2 events update a 16x6 matrix; column scans return row lines.
module cbm2_keyboard
    import cbm2_kbd_pkg::*;
#(
    parameter int ROWS = 6,
    parameter int COLS = 16
) (
    input  logic            clk_sys,
    input  logic            reset,
    input  logic [10:0]     ps2_key,
    input  logic [7:0]      col_lo_n,
    input  logic [7:0]      col_hi_n,
    output logic [ROWS-1:0] row_n,
    output logic            key_valid
);

    logic [10:0]     key_q;
    logic            tog_q;
    logic            first_q;
    logic            new_event;
    logic            lk_valid;
    kbd_entry_t      lk_entry;
    logic            lk_down;
    logic            upd;
    logic [1:0]      shift_held;
    logic [ROWS-1:0] matrix [COLS];
    logic [ROWS-1:0] eff [COLS];
    logic [COLS-1:0] sel_n;
    logic [ROWS-1:0] rows_hit;

    // Capture key events; first sample after reset only seeds history
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            key_q   <= '0;
            tog_q   <= 1'b0;
            first_q <= 1'b1;
        end else begin
            key_q   <= ps2_key;
            tog_q   <= first_q ? ps2_key[10] : key_q[10];
            first_q <= 1'b0;
        end
    end

    assign new_event = !first_q && (key_q[10] != tog_q);

    cbm2_keymap u_keymap (
        .clk      (clk_sys),
        .reset    (reset),
        .req      (new_event),
        .ext      (key_q[8]),
        .code     (key_q[7:0]),
        .pressed  (key_q[9]),
        .valid    (lk_valid),
        .entry    (lk_entry),
        .key_down (lk_down)
    );

    assign upd = lk_valid && lk_entry.hit;

    // Matrix write for ordinary keys (stage 2)
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            for (int c = 0; c < COLS; c++) matrix[c] <= '0;
        end else if (upd && lk_entry.shift_id == 2'd0) begin
            matrix[lk_entry.col][lk_entry.row] <= lk_down;
        end
    end

    // Per-shift held bits so either shift keeps the shared cell down
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            shift_held <= 2'b00;
        end else if (upd) begin
            if (lk_entry.shift_id == 2'd1) shift_held[0] <= lk_down;
            if (lk_entry.shift_id == 2'd2) shift_held[1] <= lk_down;
        end
    end

    // Debug strobe for each mapped event written
    always_ff @(posedge clk_sys) begin
        if (reset) key_valid <= 1'b0;
        else       key_valid <= upd;
    end

    // Effective matrix with the shared shift cell merged in
    always_comb begin
        for (int c = 0; c < COLS; c++) eff[c] = matrix[c];
        eff[SHIFT_COL][SHIFT_ROW] = |shift_held;
    end

    assign sel_n = {col_hi_n, col_lo_n};

    // OR rows of every selected (low) column
    always_comb begin
        rows_hit = '0;
        for (int c = 0; c < COLS; c++) begin
            if (!sel_n[c]) rows_hit = rows_hit | eff[c];
        end
    end

    // Registered active-low row response
    always_ff @(posedge clk_sys) begin
        if (reset) row_n <= '1;
        else       row_n <= ~rows_hit;
    end

endmodule

// File: tb/tb_cbm2_keyboard.sv
// Bench for cbm2_keyboard: event vectors plus reset,
// scan-latency, burst and mid-flight reset sequences.
module tb_cbm2_keyboard;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic [7:0]  col_lo_n;
    logic [7:0]  col_hi_n;
    logic [5:0]  row_n;
    logic        key_valid;

    int checks = 0;
    int errors = 0;
    logic tog;

    cbm2_keyboard dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ps2_key   (ps2_key),
        .col_lo_n  (col_lo_n),
        .col_hi_n  (col_hi_n),
        .row_n     (row_n),
        .key_valid (key_valid)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic        pressed;
        logic        ext;
        logic [7:0]  code;
        logic [15:0] sel_n;
        logic        exp_kv;
        logic [5:0]  exp_row;
    } vec_t;

    vec_t vecs [15];

    task automatic tick();
        @(posedge clk_sys);
        @(negedge clk_sys);
    endtask

    task automatic set_cols(input logic [15:0] s);
        col_lo_n = s[7:0];
        col_hi_n = s[15:8];
    endtask

    task automatic send(input logic p, input logic e,
                        input logic [7:0] code);
        tog = ~tog;
        ps2_key = {tog, p, e, code};
    endtask

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic kv_exp [6];

    initial begin
        // A: col1 row3, S: col2 row3, shift cell col0 row4,
        // cursor up (E0 75): col11 row0, keypad 8 (75): col12 row5
        vecs[0]  = '{1'b1, 1'b0, 8'h1C, 16'hFFFD, 1'b1, 6'h37};
        vecs[1]  = '{1'b0, 1'b0, 8'h1C, 16'hFFFD, 1'b1, 6'h3F};
        vecs[2]  = '{1'b1, 1'b0, 8'h12, 16'hFFFE, 1'b1, 6'h2F};
        vecs[3]  = '{1'b1, 1'b0, 8'h59, 16'hFFFE, 1'b1, 6'h2F};
        vecs[4]  = '{1'b0, 1'b0, 8'h12, 16'hFFFE, 1'b1, 6'h2F};
        vecs[5]  = '{1'b0, 1'b0, 8'h59, 16'hFFFE, 1'b1, 6'h3F};
        vecs[6]  = '{1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 6'h3F};
        vecs[7]  = '{1'b1, 1'b1, 8'h75, 16'hF7FF, 1'b1, 6'h3E};
        vecs[8]  = '{1'b1, 1'b0, 8'h75, 16'hF7FF, 1'b1, 6'h3E};
        vecs[9]  = '{1'b1, 1'b0, 8'h75, 16'hEFFF, 1'b1, 6'h1F};
        vecs[10] = '{1'b0, 1'b1, 8'h75, 16'hF7FF, 1'b1, 6'h3F};
        vecs[11] = '{1'b0, 1'b0, 8'h75, 16'hEFFF, 1'b1, 6'h3F};
        vecs[12] = '{1'b0, 1'b0, 8'h1C, 16'hFFFD, 1'b1, 6'h3F};
        vecs[13] = '{1'b1, 1'b0, 8'h1C, 16'hFFFD, 1'b1, 6'h37};
        vecs[14] = '{1'b1, 1'b0, 8'h1B, 16'hFFF9, 1'b1, 6'h37};
        kv_exp = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset with all columns low and a pending toggle on ps2_key
        tog = 1'b1;
        ps2_key = {1'b1, 1'b1, 1'b0, 8'h1C};
        reset = 1'b1;
        set_cols(16'h0000);
        @(negedge clk_sys);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_row", 16'(row_n), 16'h3F);
            check("reset_kv", 16'(key_valid), 16'h0);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("first_kv", 16'(key_valid), 16'h0);
        end
        check("first_row", 16'(row_n), 16'h3F);

        // Table-driven events
        foreach (vecs[i]) begin
            set_cols(vecs[i].sel_n);
            send(vecs[i].pressed, vecs[i].ext, vecs[i].code);
            tick();
            tick();
            check("vec_kv_n1", 16'(key_valid), 16'h0);
            tick();
            check("vec_kv_n2", 16'(key_valid), 16'(vecs[i].exp_kv));
            tick();
            check("vec_row_n3", 16'(row_n), 16'(vecs[i].exp_row));
            check("vec_kv_end", 16'(key_valid), 16'h0);
        end

        // A and S held: single column still reads row 3; 1-cycle scan
        set_cols(16'hFFFB);
        tick();
        check("scan_col2", 16'(row_n), 16'h37);
        set_cols(16'hFFFF);
        tick();
        check("scan_none", 16'(row_n), 16'h3F);
        set_cols(16'hFFFD);
        tick();
        check("scan_col1", 16'(row_n), 16'h37);

        // Burst: release A, release S, press Z on consecutive cycles
        set_cols(16'hFFF1);
        for (int i = 0; i < 6; i++) begin
            if (i == 0) send(1'b0, 1'b0, 8'h1C);
            if (i == 1) send(1'b0, 1'b0, 8'h1B);
            if (i == 2) send(1'b1, 1'b0, 8'h1A);
            tick();
            check("burst_kv", 16'(key_valid), 16'(kv_exp[i]));
        end
        check("burst_row", 16'(row_n), 16'h2F);

        // Reset while an event sits in stage 1
        send(1'b1, 1'b0, 8'h22);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_cols(16'hFFF9);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("midrst_kv", 16'(key_valid), 16'h0);
        end
        check("midrst_row", 16'(row_n), 16'h3F);

        // Normal operation resumes after reset
        set_cols(16'hFFFD);
        send(1'b1, 1'b0, 8'h1C);
        tick();
        tick();
        tick();
        check("post_kv", 16'(key_valid), 16'h1);
        tick();
        check("post_row", 16'(row_n), 16'h37);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cbm2_keyboard.md
# cbm2_keyboard

Keyboard matrix responder for the CBM-II core. It turns MiSTer PS/2 key events into a 16-column × 6-row key matrix. It answers the keyboard scan that TPI2 drives:

- TPI2 drives the column lines: PB = columns 0–7, PA = columns 8–15.
- The block returns row lines 0–5 on TPI2 PC[5:0].

It sits between the HPS keyboard input and the TPI2 port pins in `cbm2_main`.

## Interface

Parameters:
- `ROWS`, default 6: matrix rows, which are the TPI2 PC inputs.
- `COLS`, default 16: matrix columns, which are the TPI2 PA/PB outputs.

Ports:
- `clk_sys` input 1: system clock.
- `reset` input 1: synchronous, active-high reset.
- `ps2_key` input 11: MiSTer key event.
  - [10] toggles once per event.
  - [9] is 1 for pressed, 0 for released.
  - [8] is the E0 extended flag.
  - [7:0] is the scancode.
- `col_lo_n` input 8: TPI2 PB out. Column c is selected when bit c = 0.
- `col_hi_n` input 8: TPI2 PA out. Column 8+c is selected when bit c = 0.
- `row_n` output 6: to TPI2 PC_in[5:0]. Active low: 0 = a pressed key in a selected column.
- `key_valid` output 1: one-cycle pulse when a mapped event has been written into the matrix. Used for debug and the bench.

## Operation

- **Event capture.** The block registers `ps2_key` each cycle into `key_q`. A new event exists when `key_q[10]` differs from the previously registered toggle bit. The first sample after reset only loads the toggle history and never produces an event.
- **Lookup (stage 1).** The event's `{ext, scancode}` is registered together with `pressed`. The lookup returns `{hit, col[3:0], row[2:0], shift_id[1:0]}`. The result is registered.
  - Unmapped codes give `hit = 0`. They are dropped: no matrix change and no `key_valid`.
- **Matrix update (stage 2).** For a hit, `matrix[col][row]` is set to `pressed` and `key_valid` pulses.
- **Shift keys.**
  - Left shift (12) and right shift (59) share one matrix cell.
  - Each physical shift has its own held bit (`shift_id` 1 or 2).
  - The shared cell is the OR of the two held bits. Releasing one shift while the other is held keeps the cell pressed.
- **Repeats.** A repeated press of a key already held is idempotent. A release of a key not held is idempotent.
- **Scan response.** `row_n[r]` = NOT( OR over all c of (`matrix[c][r]` AND column c selected) ). The result is registered.
  - Several columns low: their rows are OR-combined.
  - All columns high: `row_n` = 6'h3F.

## Timing

- **Reset values.**
  - Whole matrix is released and both shift held bits are 0.
  - `row_n` = 6'h3F and `key_valid` = 0.
  - Toggle history loads from `ps2_key[10]` on the first cycle after reset deasserts.
- **Event latency.** A toggle change sampled at edge N gives:
  - lookup registered at N+1;
  - matrix written and `key_valid` high at N+2;
  - `row_n` reflecting the change at N+3, given an unchanged column select.
- **Scan latency.** `row_n` follows a column-select change by exactly 1 cycle. This is well inside a TPI2 access (4 clk_sys cycles per CPU cycle).
- **Back-to-back events.** One event per cycle is accepted; the pipeline has no stall. Toggles arriving on consecutive cycles are each processed in order.
- **Reset mid-operation.** Reset cancels events in flight. An event in stage 1 is not written.

## Structure

- **Package `cbm2_kbd_pkg`:**
  - keymap entry typedef `{hit, col, row, shift_id}`;
  - scancode constants for the shift keys;
  - the CBM-II scancode → (col,row) table as a constant function `kbd_lookup(ext, code)`.
- **Sub-module `cbm2_keymap`:** registered lookup ROM (stage 1), 512 entries indexed by `{ext, code}`. This lets the table be inferred as block RAM.
- **Top:** edge detect, matrix register array, shift held bits, row reduction.

## Test plan

- **Reset.** Assert reset for 3 cycles with all columns low (`col_lo_n` = `col_hi_n` = 8'h00) → `row_n` = 6'h3F, `key_valid` never pulses.
- **Press A, mapped to (Ca,Ra) in `cbm2_kbd_pkg`.** Toggle `ps2_key` to {t,1,0,8'h1C}:
  - `key_valid` high at N+2;
  - only column Ca low → `row_n[Ra]` = 0, all other bits 1, at N+3;
  - all columns high → 6'h3F.
- **Release A.** {t',0,0,8'h1C} → with column Ca low, `row_n` returns to 6'h3F at N+3.
- **Dual shift.** Press 8'h12, press 8'h59, release 8'h12 → shift cell still reads 0. Then release 8'h59 → shift cell reads 1.
- **Unmapped and extended codes.**
  - {t,1,0,8'h00} → no `key_valid`, matrix unchanged.
  - {t,1,1,8'h75} (cursor up) → its table cell is pressed, and is distinct from {t,1,0,8'h75}.
- **Multi-column and burst.**
  - Press two keys in different columns and the same row, then drive both columns low → that row reads 0. Drive only one column low → still 0, because that key is held.
  - Toggles on 3 consecutive cycles → 3 `key_valid` pulses on 3 consecutive cycles.
